// File: rtl/channel_mixer.sv
// channel_mixer: gain-scaled, time-multiplexed mix of NUM_CHANNELS waveforms into one saturated sample
module channel_mixer #(
  parameter int              NUM_CHANNELS = 2,
  parameter int              WIDTH        = 24,
  parameter logic [WIDTH-1:0] WAVE_MAX    = 24'hFFFFFF,
  parameter int              GAIN_W       = 8,
  parameter int              OUT_SHIFT    = $clog2(NUM_CHANNELS),
  parameter logic [15:0]     ADDR         = 16'h0100
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [15:0]                   BusAddress,
  input  logic [7:0]                    BusData,
  input  logic                          BusWrite,
  input  logic [NUM_CHANNELS*WIDTH-1:0] Waveforms,
  input  logic                          SampleTick,
  output logic [WIDTH-1:0]              Waveform,
  output logic                          SampleValid,
  output logic                          Busy,
  output logic                          Overrun
);
  localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int PW = WIDTH + GAIN_W;
  localparam int AW = WIDTH + GAIN_W + $clog2(NUM_CHANNELS);
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << (GAIN_W - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [WIDTH-1:0]        wave_snap_q [NUM_CHANNELS];
  logic [WIDTH-1:0]        wave_snap_d [NUM_CHANNELS];
  logic [GAIN_W-1:0]       gain_snap_q [NUM_CHANNELS];
  logic [GAIN_W-1:0]       gain_snap_d [NUM_CHANNELS];
  logic [GAIN_W-1:0]       gain_q [NUM_CHANNELS];
  logic [GAIN_W-1:0]       gain_d [NUM_CHANNELS];
  logic                    enable_q, enable_d;
  logic                    overrun_q, overrun_d;
  logic [WIDTH-1:0]        waveform_q, waveform_d;
  logic [PW-1:0]           prod;
  logic [AW-1:0]           sum;
  logic [AW-1:0]           scaled;
  logic [WIDTH-1:0]        sat;

  // The final accumulation and saturation are folded into the last ACCUM cycle so the
  // new sample is already registered when OUT raises SampleValid.
  assign prod        = PW'(wave_snap_q[idx_q]) * PW'(gain_snap_q[idx_q]);
  assign sum         = acc_q + AW'(prod >> (GAIN_W - 1));
  assign scaled      = sum >> OUT_SHIFT;
  assign sat         = scaled > AW'(WAVE_MAX) ? WAVE_MAX : scaled[WIDTH-1:0];
  assign Waveform    = waveform_q;
  assign SampleValid = state_q == OUT;
  assign Busy        = state_q != IDLE;
  assign Overrun     = overrun_q;

  // Register writes, overrun tracking and the IDLE/ACCUM/OUT sequencing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    wave_snap_d = wave_snap_q;
    gain_snap_d = gain_snap_q;
    gain_d      = gain_q;
    enable_d    = enable_q;
    overrun_d   = overrun_q;
    waveform_d  = waveform_q;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (BusWrite && BusAddress == ADDR + 16'(i)) gain_d[i] = BusData[GAIN_W-1:0];
    if (BusWrite && BusAddress == ADDR + 16'(NUM_CHANNELS)) begin
      enable_d = BusData[0];
      if (BusData[1]) overrun_d = 1'b0;
    end
    if (SampleTick && state_q != IDLE) overrun_d = 1'b1;
    case (state_q)
      IDLE: if (SampleTick && enable_q) begin
        for (int i = 0; i < NUM_CHANNELS; i++) wave_snap_d[i] = Waveforms[i*WIDTH +: WIDTH];
        gain_snap_d = gain_q;
        acc_d       = '0;
        idx_d       = '0;
        state_d     = ACCUM;
      end
      ACCUM: begin
        acc_d = sum;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_CHANNELS - 1)) begin
          waveform_d = sat;
          state_d    = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset to unity gains, disabled, idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      wave_snap_q <= '{default: '0};
      gain_snap_q <= '{default: UNITY};
      gain_q      <= '{default: UNITY};
      enable_q    <= 1'b0;
      overrun_q   <= 1'b0;
      waveform_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      wave_snap_q <= wave_snap_d;
      gain_snap_q <= gain_snap_d;
      gain_q      <= gain_d;
      enable_q    <= enable_d;
      overrun_q   <= overrun_d;
      waveform_q  <= waveform_d;
    end
  end
endmodule

// File: tb/tb_channel_mixer.sv
// tb_channel_mixer: randomized scoreboard bench for channel_mixer against a sample-level reference model
module tb_channel_mixer;
  localparam int N  = 2;
  localparam int W  = 24;
  localparam int GW = 8;
  localparam int SH = 1;

  logic         Clock = 0;
  logic         Reset = 1;
  logic [15:0]  BusAddress = '0;
  logic [7:0]   BusData = '0;
  logic         BusWrite = 0;
  logic [N*W-1:0] Waveforms = '0;
  logic         SampleTick = 0;
  logic [W-1:0] Waveform;
  logic         SampleValid, Busy, Overrun;

  channel_mixer #(.NUM_CHANNELS(N)) dut (
    .Clock(Clock), .Reset(Reset), .BusAddress(BusAddress), .BusData(BusData),
    .BusWrite(BusWrite), .Waveforms(Waveforms), .SampleTick(SampleTick),
    .Waveform(Waveform), .SampleValid(SampleValid), .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  typedef struct {int due; logic [W-1:0] val;} exp_t;
  exp_t q[$];
  exp_t e;
  int gain_m[N];
  bit en_m, ovr_m, started, ovr_set, accept;
  int rem, cyc, off;
  logic [W-1:0] wave_m;
  int checks, passes;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [W-1:0] mix_ref();
    longint s = 0;
    logic [N*W-1:0] wv = Waveforms;
    for (int c = 0; c < N; c++) s += (longint'(wv[c*W +: W]) * gain_m[c]) / (1 << (GW - 1));
    s = s / (1 << SH);
    return s > 64'hFFFFFF ? 24'hFFFFFF : W'(s);
  endfunction

  // Reference model: one accepted tick yields one expected sample N+1 cycles later.
  always @(posedge Clock) begin
    if (Reset) begin
      q.delete();
      foreach (gain_m[c]) gain_m[c] = 128;
      en_m = 0; ovr_m = 0; rem = 0; wave_m = '0; started = 1;
    end else begin
      ovr_set = SampleTick && rem > 0;
      accept  = SampleTick && rem == 0 && en_m;
      if (rem > 0) rem--;
      if (accept) begin
        q.push_back('{cyc + N + 1, mix_ref()});
        rem = N + 1;
      end
      if (BusWrite) begin
        off = int'(BusAddress) - 'h100;
        if (off >= 0 && off < N) gain_m[off] = int'(BusData);
        else if (off == N) begin
          en_m = BusData[0];
          if (BusData[1]) ovr_m = 0;
        end
      end
      if (ovr_set) ovr_m = 1;
    end
    cyc++;
  end

  // Monitor: compares outputs each cycle and pops the scoreboard on SampleValid.
  always @(negedge Clock) begin
    if (started && !Reset) begin
      chk("busy", Busy, rem > 0);
      chk("overrun", Overrun, ovr_m);
      if (SampleValid && q.size() == 0) chk("spurious_valid", SampleValid, 0);
      else if (SampleValid) begin
        e = q.pop_front();
        chk("valid_cycle", cyc, e.due);
        chk("waveform", Waveform, e.val);
        wave_m = e.val;
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missed_valid", SampleValid, 1);
          e = q.pop_front();
        end
        chk("waveform_hold", Waveform, wave_m);
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
    BusWrite = 0;
    SampleTick = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    BusAddress = a; BusData = d; BusWrite = 1;
    step();
  endtask

  task automatic tick();
    SampleTick = 1;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic waves(input logic [W-1:0] c0, input logic [W-1:0] c1);
    Waveforms = {c1, c0};
  endtask

  initial begin
    Reset = 1;
    idle(2);
    Reset = 0;
    waves(24'h400000, 24'h200000);
    tick(); idle(5);
    wr(16'h0102, 8'h01);
    tick(); idle(4);
    wr(16'h0100, 8'hFF); wr(16'h0101, 8'hFF);
    waves(24'hFFFFFF, 24'hFFFFFF);
    tick(); idle(4);
    wr(16'h0101, 8'h00); wr(16'h0100, 8'h80);
    waves(24'h100000, 24'hFFFFFF);
    tick(); idle(4);
    wr(16'h0101, 8'h80);
    waves(24'h400000, 24'h200000);
    tick(); tick(); idle(4);
    wr(16'h0102, 8'h03);
    tick(); idle(4);
    waves(24'h400000, 24'h000000);
    tick(); wr(16'h0100, 8'h00); idle(3);
    tick(); idle(4);
    wr(16'h0100, 8'h80);
    tick(); step();
    Reset = 1; step(); Reset = 0;
    tick(); idle(4);
    wr(16'h0102, 8'h01);
    tick(); idle(4);
    for (int i = 0; i < 400; i++) begin
      Waveforms = {$urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'($urandom),
                   $urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'($urandom)};
      if ($urandom_range(0, 199) == 0) Reset = 1;
      if ($urandom_range(0, 2) == 0) SampleTick = 1;
      if ($urandom_range(0, 4) == 0) begin
        BusAddress = 16'h0100 + 16'($urandom_range(0, 3));
        BusData = 8'($urandom) | ($urandom_range(0, 5) != 0 ? 8'h01 : 8'h00);
        BusWrite = 1;
      end
      step();
      Reset = 0;
    end
    idle(N + 4);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
